// File: rtl/toeplitz_seed_loader_if.sv
// rtl/toeplitz_seed_loader_if.sv - Seed word stream handshake between the host/DMA source and the loader.
interface toeplitz_seed_loader_if #(
  parameter int BS = 64
) ();
  logic [BS-1:0] s_data;
  logic          s_valid;
  logic          s_ready;

  modport master (
    output s_data,
    output s_valid,
    input  s_ready
  );

  modport slave (
    input  s_data,
    input  s_valid,
    output s_ready
  );
endinterface

// File: rtl/toeplitz_seed_loader.sv
// rtl/toeplitz_seed_loader.sv - Assembles streamed column/row seed words into shadow registers and
// commits them as the row0/rrow0/col0 vectors of the Toeplitz multiplier.
module toeplitz_seed_loader #(
  parameter int BS = 64,
  parameter int N  = 256,
  parameter int L  = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  toeplitz_seed_loader_if.slave s,
  output logic [N-1:0]          row0,
  output logic [N-1:0]          rrow0,
  output logic [L-1:0]          col0,
  output logic                  busy,
  output logic                  done,
  output logic                  seed_valid
);
  localparam int XSZ   = (BS > 0) ? N / BS : 0;
  localparam int YSZ   = (BS > 0) ? L / BS : 0;
  localparam int MAXSZ = (XSZ > YSZ) ? XSZ : YSZ;
  localparam int CW    = (MAXSZ > 0) ? $clog2(MAXSZ + 1) : 1;

  if (BS < 1) begin : g_bad_bs
    $error("toeplitz_seed_loader: BS must be at least 1");
  end else if ((N % BS) != 0 || (L % BS) != 0 || XSZ < 1 || YSZ < 1) begin : g_bad_geom
    $error("toeplitz_seed_loader: N and L must be non-zero multiples of BS");
  end

  typedef enum logic [1:0] {
    IDLE,
    LOAD_COL,
    LOAD_ROW,
    FINISH
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [L-1:0]    col_sh_q, col_sh_d;
  logic [N-1:0]    row_sh_q, row_sh_d;
  logic [N-1:0]    row0_q, row0_d;
  logic [N-1:0]    rrow0_q, rrow0_d;
  logic [L-1:0]    col0_q, col0_d;
  logic            s_ready_q, s_ready_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            seed_valid_q, seed_valid_d;
  logic            beat;
  logic [N-1:0]    row_shift;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    col_sh_d     = col_sh_q;
    row_sh_d     = row_sh_q;
    row0_d       = row0_q;
    rrow0_d      = rrow0_q;
    col0_d       = col0_q;
    seed_valid_d = seed_valid_q;
    done_d       = 1'b0;
    beat         = s.s_valid && s_ready_q;
    // The element at R[N-1] already lives in the column, so the row image drops it.
    row_shift    = row_sh_q << 1;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD_COL;
          cnt_d   = '0;
        end
      end
      LOAD_COL: begin
        if (abort) begin
          state_d = IDLE;
        end else if (beat) begin
          for (int i = 0; i < YSZ; i++) begin
            if (cnt_q == CW'(i)) col_sh_d[(YSZ-1-i)*BS +: BS] = s.s_data;
          end
          if (cnt_q == CW'(YSZ - 1)) begin
            state_d = LOAD_ROW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      LOAD_ROW: begin
        if (abort) begin
          state_d = IDLE;
        end else if (beat) begin
          for (int i = 0; i < XSZ; i++) begin
            if (cnt_q == CW'(i)) row_sh_d[(XSZ-1-i)*BS +: BS] = s.s_data;
          end
          if (cnt_q == CW'(XSZ - 1)) begin
            state_d = FINISH;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
        if (!abort) begin
          col0_d = col_sh_q;
          row0_d = row_shift;
          for (int i = 0; i < N; i++) rrow0_d[i] = row_shift[N-1-i];
          done_d       = 1'b1;
          seed_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    s_ready_d = (state_d == LOAD_COL) || (state_d == LOAD_ROW);
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      col_sh_q     <= '0;
      row_sh_q     <= '0;
      row0_q       <= '0;
      rrow0_q      <= '0;
      col0_q       <= '0;
      s_ready_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      seed_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      col_sh_q     <= col_sh_d;
      row_sh_q     <= row_sh_d;
      row0_q       <= row0_d;
      rrow0_q      <= rrow0_d;
      col0_q       <= col0_d;
      s_ready_q    <= s_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      seed_valid_q <= seed_valid_d;
    end
  end

  assign s.s_ready  = s_ready_q;
  assign row0       = row0_q;
  assign rrow0      = rrow0_q;
  assign col0       = col0_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign seed_valid = seed_valid_q;
endmodule

// File: tb/tb_toeplitz_seed_loader.sv
// tb/tb_toeplitz_seed_loader.sv - Directed bench for toeplitz_seed_loader with a word-queue seed model.
module tb_toeplitz_seed_loader;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic start_a, abort_a, start_b, abort_b;
  toeplitz_seed_loader_if #(.BS(64)) ifa ();
  toeplitz_seed_loader_if #(.BS(32)) ifb ();

  logic [255:0] row0_a, rrow0_a;
  logic [127:0] col0_a;
  logic         busy_a, done_a, sv_a;
  logic [127:0] row0_b, rrow0_b;
  logic [63:0]  col0_b;
  logic         busy_b, done_b, sv_b;

  toeplitz_seed_loader #(.BS(64), .N(256), .L(128)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .s(ifa),
    .row0(row0_a), .rrow0(rrow0_a), .col0(col0_a),
    .busy(busy_a), .done(done_a), .seed_valid(sv_a)
  );

  toeplitz_seed_loader #(.BS(32), .N(128), .L(64)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .s(ifb),
    .row0(row0_b), .rrow0(rrow0_b), .col0(col0_b),
    .busy(busy_b), .done(done_b), .seed_valid(sv_b)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Model: words accepted in the current load, and the committed vectors built from them.
  bit           m_busy [2];
  int           m_cnt  [2];
  logic [63:0]  m_w    [2][6];
  logic [255:0] e_row  [2];
  logic [255:0] e_rrow [2];
  logic [255:0] e_col  [2];
  bit           e_done [2];
  bit           e_sv   [2];

  task automatic model_reset();
    for (int id = 0; id < 2; id++) begin
      m_busy[id] = 0; m_cnt[id] = 0;
      e_row[id] = '0; e_rrow[id] = '0; e_col[id] = '0;
      e_done[id] = 0; e_sv[id] = 0;
    end
  endtask

  task automatic model_step(input int id, input bit st, input bit ab, input bit vld,
                            input logic [63:0] d, input int bs, input int ysz, input int xsz,
                            input int n);
    logic [255:0] c, r, rr;
    e_done[id] = 0;
    if (!m_busy[id]) begin
      if (st) begin
        m_busy[id] = 1;
        m_cnt[id]  = 0;
      end
    end else if (ab) begin
      m_busy[id] = 0;
    end else if (m_cnt[id] == ysz + xsz) begin
      c = '0;
      r = '0;
      for (int k = 0; k < ysz; k++) c = (c << bs) | {192'b0, m_w[id][k]};
      for (int k = 0; k < xsz; k++) r = (r << bs) | {192'b0, m_w[id][ysz+k]};
      r  = (r << 1) & ((256'b1 << n) - 256'b1);
      rr = '0;
      for (int i = 0; i < n; i++) rr[i] = r[n-1-i];
      e_col[id] = c; e_row[id] = r; e_rrow[id] = rr;
      e_done[id] = 1; e_sv[id] = 1; m_busy[id] = 0;
    end else if (vld) begin
      m_w[id][m_cnt[id]] = d;
      m_cnt[id]++;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      model_step(0, start_a, abort_a, ifa.s_valid, ifa.s_data, 64, 2, 4, 256);
      model_step(1, start_b, abort_b, ifb.s_valid, {32'b0, ifb.s_data}, 32, 2, 4, 128);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("a_s_ready", ifa.s_ready, m_busy[0] && m_cnt[0] < 6);
      chk("a_busy", busy_a, m_busy[0]);
      chk("a_done", done_a, e_done[0]);
      chk("a_seed_valid", sv_a, e_sv[0]);
      chk("a_row0", row0_a, e_row[0]);
      chk("a_rrow0", rrow0_a, e_rrow[0]);
      chk("a_col0", {128'b0, col0_a}, e_col[0]);
      chk("b_s_ready", ifb.s_ready, m_busy[1] && m_cnt[1] < 6);
      chk("b_busy", busy_b, m_busy[1]);
      chk("b_done", done_b, e_done[1]);
      chk("b_seed_valid", sv_b, e_sv[1]);
      chk("b_row0", {128'b0, row0_b}, e_row[1]);
      chk("b_rrow0", {128'b0, rrow0_b}, e_rrow[1]);
      chk("b_col0", {192'b0, col0_b}, e_col[1]);
    end
  end

  function automatic bit get_ready(input int id);
    return (id == 0) ? ifa.s_ready : ifb.s_ready;
  endfunction

  function automatic bit get_done(input int id);
    return (id == 0) ? done_a : done_b;
  endfunction

  task automatic set_valid(input int id, input bit v, input logic [63:0] d);
    if (id == 0) begin
      ifa.s_valid = v; ifa.s_data = d;
    end else begin
      ifb.s_valid = v; ifb.s_data = d[31:0];
    end
  endtask

  task automatic set_start(input int id, input bit v);
    if (id == 0) start_a = v; else start_b = v;
  endtask

  task automatic set_abort(input int id, input bit v);
    if (id == 0) abort_a = v; else abort_b = v;
  endtask

  // Cycle 1 is the cycle after the edge that samples start; done_cyc is the cycle done is seen.
  task automatic run_load(input int id, input logic [63:0] w [6], input bit stall,
                          input int abort_after, input int start_at,
                          output int done_cyc, output int nst);
    int idx;
    bit v;
    bit aborted;
    idx = 0; nst = 0; done_cyc = -1; aborted = 0;
    @(negedge clk);
    set_start(id, 1);
    set_valid(id, 0, '0);
    @(negedge clk);
    set_start(id, 0);
    for (int c = 1; c < 60; c++) begin
      if (get_done(id)) begin
        done_cyc = c;
        break;
      end
      set_start(id, c == start_at);
      if (abort_after >= 0 && idx == abort_after) begin
        set_abort(id, 1);
        set_valid(id, 1, w[idx]);
        @(negedge clk);
        set_abort(id, 0);
        set_valid(id, 0, '0);
        aborted = 1;
        break;
      end
      if (idx < 6) begin
        v = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
        if (!v) nst++;
        set_valid(id, v, w[idx]);
        if (v && get_ready(id)) idx++;
      end else begin
        set_valid(id, 0, '0);
      end
      @(negedge clk);
    end
    set_valid(id, 0, '0);
    set_start(id, 0);
    if (!aborted) chk("load_done_seen", done_cyc >= 0, 1);
  endtask

  localparam logic [127:0] T1_COL   = 128'h0123456789ABCDEF_FEDCBA9876543210;
  localparam logic [255:0] T1_ROW   = {64'h3, 64'h3, 64'h3, 64'h2};
  localparam logic [255:0] T1_RROW  = {64'h4000000000000000, 64'hC000000000000000,
                                       64'hC000000000000000, 64'hC000000000000000};
  localparam logic [127:0] T3_COL   = 128'hAAAAAAAAAAAAAAAA_5555555555555555;
  localparam logic [255:0] T3_ROW   = {64'h2, 64'h4, 64'h6, 64'h8};

  logic [63:0] w1 [6];
  logic [63:0] w3 [6];
  logic [63:0] wb1 [6];
  logic [63:0] wb2 [6];
  int dc, ns;

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    w1  = '{64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 64'h8000000000000001,
            64'h8000000000000001, 64'h8000000000000001, 64'h8000000000000001};
    w3  = '{64'hAAAAAAAAAAAAAAAA, 64'h5555555555555555, 64'h1, 64'h2, 64'h3, 64'h4};
    wb1 = '{64'h11111111, 64'h22222222, 64'h01234567, 64'h89ABCDEF, 64'hDEADBEEF, 64'hCAFEF00D};
    wb2 = '{64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFF};
    rst_n = 1'b0;
    start_a = 0; abort_a = 0; start_b = 0; abort_b = 0;
    ifa.s_valid = 0; ifa.s_data = '0;
    ifb.s_valid = 0; ifb.s_data = '0;

    #12;
    chk("rst_row0", row0_a, '0);
    chk("rst_rrow0", rrow0_a, '0);
    chk("rst_col0", {128'b0, col0_a}, '0);
    chk("rst_flags", {ifa.s_ready, busy_a, done_a, sv_a}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_load(0, w1, 0, -1, -1, dc, ns);
    chk("t1_done_cycle", dc, 8);
    chk("t1_col0", {128'b0, col0_a}, {128'b0, T1_COL});
    chk("t1_row0", row0_a, T1_ROW);
    chk("t1_rrow0", rrow0_a, T1_RROW);
    chk("t1_seed_valid", sv_a, 1);

    for (int r = 0; r < 3; r++) begin
      run_load(0, w1, 1, -1, -1, dc, ns);
      chk("t2_done_cycle", dc, 8 + ns);
      chk("t2_col0", {128'b0, col0_a}, {128'b0, T1_COL});
      chk("t2_row0", row0_a, T1_ROW);
      chk("t2_rrow0", rrow0_a, T1_RROW);
    end

    run_load(0, w3, 0, 3, -1, dc, ns);
    chk("t3_busy_after_abort", busy_a, 0);
    chk("t3_done_after_abort", done_a, 0);
    chk("t3_col0_held", {128'b0, col0_a}, {128'b0, T1_COL});
    chk("t3_row0_held", row0_a, T1_ROW);
    run_load(0, w3, 0, -1, -1, dc, ns);
    chk("t3_done_cycle", dc, 8);
    chk("t3_col0", {128'b0, col0_a}, {128'b0, T3_COL});
    chk("t3_row0", row0_a, T3_ROW);

    @(negedge clk);
    start_a = 1;
    @(negedge clk);
    start_a = 0;
    for (int k = 0; k < 3; k++) begin
      set_valid(0, 1, w1[k]);
      @(negedge clk);
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("t4_row0", row0_a, '0);
    chk("t4_rrow0", rrow0_a, '0);
    chk("t4_col0", {128'b0, col0_a}, '0);
    chk("t4_flags", {ifa.s_ready, busy_a, done_a, sv_a}, 4'b0000);
    set_valid(0, 0, '0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t4_idle_busy", busy_a, 0);
    chk("t4_idle_ready", ifa.s_ready, 0);

    for (int k = 0; k < 5; k++) begin
      set_valid(0, 1, 64'hDEADDEADDEADDEAD);
      @(negedge clk);
      chk("t5_idle_ready", ifa.s_ready, 0);
    end
    set_valid(0, 0, '0);
    run_load(0, w1, 0, -1, 4, dc, ns);
    chk("t5_done_cycle", dc, 8);
    chk("t5_col0", {128'b0, col0_a}, {128'b0, T1_COL});
    chk("t5_row0", row0_a, T1_ROW);

    run_load(1, wb1, 0, -1, -1, dc, ns);
    chk("t6_first_done_cycle", dc, 8);
    chk("t6_first_col0", {192'b0, col0_b}, {192'b0, 64'h11111111_22222222});
    run_load(1, wb2, 1, -1, -1, dc, ns);
    chk("t6_done_cycle", dc, 8 + ns);
    chk("t6_col0", {192'b0, col0_b}, {192'b0, {64{1'b1}}});
    chk("t6_row0", {128'b0, row0_b}, {128'b0, {127{1'b1}}, 1'b0});
    chk("t6_rrow0", {128'b0, rrow0_b}, {128'b0, 1'b0, {127{1'b1}}});

    @(negedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
